food_placer: RTL

- Consumer end of the snake game's pseudo-random number stream: turns the free-running 24-bit `random_number` into a legal food cell on the play grid.
- Legal means in range and not occupied by the snake.
- Candidates are checked against the snake occupancy memory through a one-cycle read interface.
- Sits between the random number generator, the snake body memory and the game controller, which pulses `req` at game start and whenever food is eaten.

---
 rtl/food_placer_pkg.sv | 23 ++
 rtl/food_placer_raster_counter.sv | 57 +++++
 rtl/food_placer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/food_placer_pkg.sv
// Shared snake-game definitions: grid geometry, the cell coordinate type and
// the food placer state encoding.
package food_placer_pkg;

  localparam int unsigned GRID_W  = 32;
  localparam int unsigned GRID_H  = 24;
  localparam int unsigned COORD_W = 6;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_t;

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StIssue,
    StCheck,
    StScanIssue,
    StScanCheck
  } placer_state_e;

endpackage

// File: rtl/food_placer_raster_counter.sv
// Raster-order scan pointer over the play grid with clear, advance and a
// flag marking the bottom-right cell.
module grid_raster_counter #(
  parameter int unsigned GridW  = 32,
  parameter int unsigned GridH  = 24,
  parameter int unsigned CoordW = 6
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [CoordW-1:0] x_o,
  output logic [CoordW-1:0] y_o,
  output logic              last_o
);

  localparam logic [CoordW-1:0] XLast = CoordW'(GridW - 1);
  localparam logic [CoordW-1:0] YLast = CoordW'(GridH - 1);

  logic [CoordW-1:0] x_q, x_d;
  logic [CoordW-1:0] y_q, y_d;
  logic              x_at_end, y_at_end;

  assign x_at_end = (x_q == XLast);
  assign y_at_end = (y_q == YLast);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_at_end) begin
        x_d = '0;
        y_d = y_at_end ? '0 : y_q + CoordW'(1);
      end else begin
        x_d = x_q + CoordW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_at_end && y_at_end;

endmodule

// File: rtl/food_placer.sv
// Turns the free-running random stream into a free, in-range food cell, with
// a raster-scan fallback once the random tries are exhausted.
module food_placer
  import food_placer_pkg::*;
#(
  parameter int unsigned GridW    = GRID_W,
  parameter int unsigned GridH    = GRID_H,
  parameter int unsigned CoordW   = COORD_W,
  parameter int unsigned MaxTries = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [23:0]       random_number_i,
  input  logic              req_i,
  output logic              busy_o,
  output logic              food_valid_o,
  output logic [CoordW-1:0] food_x_o,
  output logic [CoordW-1:0] food_y_o,
  output logic              board_full_o,
  output logic              occ_rd_en_o,
  output logic [CoordW-1:0] occ_x_o,
  output logic [CoordW-1:0] occ_y_o,
  input  logic              occ_hit_i
);

  localparam int unsigned CntW  = $clog2(MaxTries + 1);
  localparam int unsigned CmpW  = CoordW + 1;
  localparam logic [CntW-1:0] MaxTriesC = CntW'(MaxTries);
  localparam logic [CmpW-1:0] GridWC    = CmpW'(GridW);
  localparam logic [CmpW-1:0] GridHC    = CmpW'(GridH);

  placer_state_e     state_q, state_d;
  logic              busy_q, busy_d;
  logic              food_valid_q, food_valid_d;
  logic [CoordW-1:0] food_x_q, food_x_d;
  logic [CoordW-1:0] food_y_q, food_y_d;
  logic              board_full_q, board_full_d;
  logic              occ_rd_en_q, occ_rd_en_d;
  logic [CoordW-1:0] occ_x_q, occ_x_d;
  logic [CoordW-1:0] occ_y_q, occ_y_d;
  logic [CntW-1:0]   try_cnt_q, try_cnt_d;
  // Second cycle of a scan check, when occ_hit_i is valid.
  logic              scan_phase_q, scan_phase_d;

  logic              scan_clear, scan_advance, scan_last;
  logic [CoordW-1:0] scan_x, scan_y;
  logic [CoordW-1:0] cand_x, cand_y;
  logic              cand_ok;
  logic [CntW-1:0]   try_inc;
  logic              unused_rnd;

  assign cand_x     = random_number_i[CoordW-1:0];
  assign cand_y     = random_number_i[2*CoordW-1:CoordW];
  assign unused_rnd = ^random_number_i[23:2*CoordW];
  assign cand_ok    = ({1'b0, cand_x} < GridWC) && ({1'b0, cand_y} < GridHC);
  assign try_inc    = try_cnt_q + CntW'(1);

  grid_raster_counter #(
    .GridW  (GridW),
    .GridH  (GridH),
    .CoordW (CoordW)
  ) u_scan (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (scan_clear),
    .advance_i (scan_advance),
    .x_o       (scan_x),
    .y_o       (scan_y),
    .last_o    (scan_last)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    food_valid_d = 1'b0;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    board_full_d = board_full_q;
    occ_rd_en_d  = occ_rd_en_q;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    try_cnt_d    = try_cnt_q;
    scan_phase_d = scan_phase_q;
    scan_clear   = 1'b0;
    scan_advance = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d      = StSample;
          busy_d       = 1'b1;
          board_full_d = 1'b0;
          try_cnt_d    = '0;
        end
      end
      StSample: begin
        try_cnt_d = try_inc;
        if (cand_ok) begin
          occ_x_d     = cand_x;
          occ_y_d     = cand_y;
          occ_rd_en_d = 1'b1;
          state_d     = StIssue;
        end else if (try_inc == MaxTriesC) begin
          scan_clear = 1'b1;
          state_d    = StScanIssue;
        end
      end
      StIssue: begin
        occ_rd_en_d = 1'b0;
        state_d     = StCheck;
      end
      StCheck: begin
        if (!occ_hit_i) begin
          food_x_d     = occ_x_q;
          food_y_d     = occ_y_q;
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end else if (try_cnt_q == MaxTriesC) begin
          scan_clear = 1'b1;
          state_d    = StScanIssue;
        end else begin
          state_d = StSample;
        end
      end
      StScanIssue: begin
        occ_x_d      = scan_x;
        occ_y_d      = scan_y;
        occ_rd_en_d  = 1'b1;
        scan_phase_d = 1'b0;
        state_d      = StScanCheck;
      end
      StScanCheck: begin
        if (!scan_phase_q) begin
          occ_rd_en_d  = 1'b0;
          scan_phase_d = 1'b1;
        end else if (!occ_hit_i) begin
          food_x_d     = occ_x_q;
          food_y_d     = occ_y_q;
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end else if (scan_last) begin
          board_full_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end else begin
          scan_advance = 1'b1;
          state_d      = StScanIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      food_valid_q <= 1'b0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      board_full_q <= 1'b0;
      occ_rd_en_q  <= 1'b0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      try_cnt_q    <= '0;
      scan_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      food_valid_q <= food_valid_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      board_full_q <= board_full_d;
      occ_rd_en_q  <= occ_rd_en_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      try_cnt_q    <= try_cnt_d;
      scan_phase_q <= scan_phase_d;
    end
  end

  assign busy_o       = busy_q;
  assign food_valid_o = food_valid_q;
  assign food_x_o     = food_x_q;
  assign food_y_o     = food_y_q;
  assign board_full_o = board_full_q;
  assign occ_rd_en_o  = occ_rd_en_q;
  assign occ_x_o      = occ_x_q;
  assign occ_y_o      = occ_y_q;

endmodule
